fft_sample_sequencer: RTL
=========================

# fft_sample_sequencer

Parametrised sample sequencer for the FFT stage. It owns the FFT working RAM port outside a transform. It loads N_POINTS input samples after a programmable start delay, in natural or bit-reversed order, then pulses the FFT core and waits for its finish. It then streams the N_POINTS results out over a valid/ready interface. It replaces the fixed 16-sample counter loader with a generic, handshaked block usable for 16/32/64-point builds.

## Interface
- N_POINTS, 32, transform length; power of two, 4..1024
- ADDR_W, 5, RAM address width; equals log2(N_POINTS)
- DATA_W, 16, sample/result word width
- START_DELAY, 4, idle cycles between accepted start and first in_ready; 0..255

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  begin a transform; sampled only in IDLE
- in_valid  in  1  input sample valid
- in_data  in  DATA_W  input sample
- in_ready  out  1  sequencer accepts a sample this cycle
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address (write in LOAD, read in DRAIN)
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after address
- fft_start  out  1  single-cycle FFT kick
- fft_finish  in  1  FFT complete (level or pulse)
- out_valid  out  1  result valid
- out_data  out  DATA_W  result word
- out_last  out  1  marks result index N_POINTS-1
- out_ready  in  1  downstream accepts result
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse after last result accepted

## Operation
- States: IDLE, DELAY, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> DELAY.
  - If START_DELAY=0, start=1 -> LOAD directly.
  - start in any other state is ignored.
- DELAY: counter runs 0..START_DELAY-1, then -> LOAD.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready cycle sets ram_we=1, ram_wdata=in_data, ram_addr=f(k), where k is the write count 0..N_POINTS-1.
  - After write k=N_POINTS-1: -> RUN, k wraps to 0.
  - Exactly N_POINTS writes; no extra or skipped address.
- RUN:
  - fft_start=1 for the first RUN cycle only.
  - RAM outputs are idle: ram_we=0, ram_addr=0.
  - fft_finish=1 -> DRAIN. fft_finish is ignored in all other states, including the fft_start cycle itself.
- DRAIN:
  - Read index r=0..N_POINTS-1 in natural order.
  - A read is issued when the output register is empty or is being consumed this cycle (out_valid&out_ready).
  - Data lands in out_data one cycle after issue.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
  - out_last=1 with index N_POINTS-1.
  - Last accepted transfer -> DONE.
- DONE: done=1 for one cycle, then -> IDLE.
- Reset (asynchronous, any state, including mid-LOAD or mid-DRAIN) forces:
  - state=IDLE, all counters 0;
  - in_ready, ram_we, ram_addr, ram_wdata, fft_start, out_valid, out_data, out_last, busy, done all 0.
  - Partial loads are discarded.

## Timing
- start at cycle t in IDLE: busy=1 from t+1; first in_ready=1 at t+1+START_DELAY.
- Write latency 0: RAM signals are combinational from the handshake in the same cycle.
- Back-to-back input: N_POINTS consecutive cycles; fft_start on the cycle after the last write.
- Drain latency: first out_valid 2 cycles after fft_finish is sampled (1 cycle read issue, 1 cycle RAM latency).
- Drain rate with out_ready held 1: one result per cycle.
- Minimum full transform overhead beyond FFT compute: 1+START_DELAY+N_POINTS+1+2+N_POINTS+1 cycles.
- in_valid with in_ready=0 is ignored and must not write.

## Configuration
- BITREV_LOAD_EN defined: f(k) = bit-reverse of k over ADDR_W bits, so the RAM holds samples in decimation-in-time input order and results drain naturally.
- BITREV_LOAD_EN undefined: f(k)=k, natural order load; the FFT core is responsible for reordering.
- Drain order is natural in both builds.

## Test plan
- Natural load (macro off, N_POINTS=16, START_DELAY=4): start pulse at cycle 10, in_valid constant, in_data=k -> ram_addr 0..15 on cycles 15..30 with ram_wdata=addr; fft_start at cycle 31 only.
- Bit-reversed load (macro on, N_POINTS=32): write k=1 -> ram_addr=16; k=3 -> 24; k=31 -> 31; exactly 32 ram_we pulses.
- Input gaps: in_valid toggling 1,0,1,0 -> writes only on valid cycles, ram_addr sequence unbroken, fft_start after the 16th write.
- Drain backpressure: model RAM returns 0x100+addr; out_ready low every third cycle -> out_data 0x100..0x10F in order, each held while stalled; out_last with 0x10F; done one cycle after its acceptance.
- Ignored events: fft_finish=1 during LOAD and start=1 during RUN -> no state change; DRAIN is entered only on fft_finish in RUN.
- Reset mid-operation: RST high after write 7 -> all outputs 0 immediately; a new start loads from address 0 again.

Source files
------------

// File: rtl/fft_sample_sequencer.sv
// Sample sequencer around the FFT working RAM: delayed start, handshaked load, FFT kick, handshaked drain.
// Define BITREV_LOAD_EN to load samples in bit-reversed address order; otherwise loads are natural order.
module fft_sample_sequencer #(
  parameter int N_POINTS    = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 16,
  parameter int START_DELAY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              fft_start,
  input  logic              fft_finish,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0]        DLY_LAST = 8'((START_DELAY > 0) ? (START_DELAY - 1) : 0);
  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(N_POINTS - 1);
  localparam logic [ADDR_W:0]   RD_LAST  = (ADDR_W + 1)'(N_POINTS - 1);
  localparam logic [ADDR_W:0]   RD_END   = (ADDR_W + 1)'(N_POINTS);

  state_t              state;
  logic [7:0]          dly_cnt;
  logic [ADDR_W-1:0]   wr_cnt;
  logic [ADDR_W:0]     rd_cnt;
  logic                out_fresh;
  logic [DATA_W-1:0]   out_hold;
  logic                wr_fire;
  logic                rd_fire;

  function automatic logic [ADDR_W-1:0] load_addr(input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] a;
`ifdef BITREV_LOAD_EN
    for (int i = 0; i < ADDR_W; i++) begin
      a[i] = k[ADDR_W-1-i];
    end
`else
    a = k;
`endif
    return a;
  endfunction

  assign wr_fire = in_ready & in_valid;
  assign rd_fire = (state == S_DRAIN) && (rd_cnt != RD_END) && (!out_valid || out_ready);

  // The word read last cycle is presented straight from the RAM; a stalled word is parked in out_hold.
  assign out_data = out_fresh ? ram_rdata : out_hold;

  always_comb begin
    ram_we    = wr_fire;
    ram_wdata = wr_fire ? in_data : '0;
    ram_addr  = '0;
    if (state == S_LOAD) begin
      ram_addr = load_addr(wr_cnt);
    end else if (state == S_DRAIN) begin
      ram_addr = rd_cnt[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      dly_cnt   <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      fft_start <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_fresh <= 1'b0;
      out_hold  <= '0;
    end else begin
      fft_start <= 1'b0;
      done      <= 1'b0;
      out_fresh <= rd_fire;
      if (out_fresh) begin
        out_hold <= ram_rdata;
      end
      if (rd_fire) begin
        out_valid <= 1'b1;
        out_last  <= (rd_cnt == RD_LAST);
        rd_cnt    <= rd_cnt + 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            dly_cnt <= '0;
            if (START_DELAY == 0) begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end else begin
              state <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (dly_cnt == DLY_LAST) begin
            dly_cnt  <= '0;
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end else begin
            dly_cnt <= dly_cnt + 8'd1;
          end
        end
        S_LOAD: begin
          if (wr_fire) begin
            if (wr_cnt == K_LAST) begin
              wr_cnt    <= '0;
              in_ready  <= 1'b0;
              fft_start <= 1'b1;
              state     <= S_RUN;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        // fft_start is still high on the first RUN cycle, so a finish seen then is ignored.
        S_RUN: begin
          if (!fft_start && fft_finish) begin
            rd_cnt <= '0;
            state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy   <= 1'b0;
          rd_cnt <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
